// File: rtl/glitc_prog_pkg.sv
// Shared definitions for the GLITC configuration sequencer: channel count,
// per-channel state encoding and the counter sizing helper.
package glitc_prog_pkg;

    localparam int unsigned NUM_GLITC = 4;
    localparam int unsigned STATE_W   = 3;

    // Encodings are visible on state_debug_o, so the values are fixed.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_REQ_WAIT  = 3'd1,
        ST_PROG_LOW  = 3'd2,
        ST_GAP       = 3'd3,
        ST_INIT_HOLD = 3'd4,
        ST_LOAD      = 3'd5,
        ST_READY     = 3'd6,
        ST_ERROR     = 3'd7
    } ch_state_e;

    // One counter serves both the pin phases and the DONE timeout, so it must
    // be wide enough for whichever of the two is larger.
    function automatic int unsigned cnt_width(input int unsigned timeout_bits,
                                              input int unsigned max_cycles);
        int unsigned w;
        w = $clog2(max_cycles + 1);
        return (w > timeout_bits) ? w : timeout_bits;
    endfunction

endpackage

// File: rtl/glitc_prog_channel.sv
// One GLITC configuration channel: DONE synchronizer, PROGRAM_B/INIT_B
// sequencing, DONE-wait timeout and the gready flag seen by the GLITCBUS master.
module glitc_prog_channel
    import glitc_prog_pkg::*;
#(
    parameter int unsigned PROG_CYCLES  = 64,
    parameter int unsigned GAP_CYCLES   = 16,
    parameter int unsigned INIT_CYCLES  = 64,
    parameter int unsigned TIMEOUT_BITS = 24
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               prog_req_i,
    input  logic               bus_busy_i,
    input  logic               done_i,
    output logic               program_b_o,
    output logic               init_b_o,
    output logic               gready_o,
    output logic               prog_err_o,
    output logic [STATE_W-1:0] state_o
);

    localparam int unsigned MAX_PHASE =
        (PROG_CYCLES > GAP_CYCLES)
            ? ((PROG_CYCLES > INIT_CYCLES) ? PROG_CYCLES : INIT_CYCLES)
            : ((GAP_CYCLES  > INIT_CYCLES) ? GAP_CYCLES  : INIT_CYCLES);
    localparam int unsigned CNT_W = cnt_width(TIMEOUT_BITS, MAX_PHASE);

    localparam logic [CNT_W-1:0] PROG_LAST    = CNT_W'(PROG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] INIT_LAST    = CNT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'({TIMEOUT_BITS{1'b1}});

    logic             done_meta;
    logic             done_s;
    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             program_b_q, program_b_d;
    logic             init_b_q, init_b_d;
    logic             gready_q, gready_d;
    logic             prog_err_q, prog_err_d;

    // Two-flop synchronizer for the asynchronous DONE pin.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            done_meta <= 1'b0;
            done_s    <= 1'b0;
        end else begin
            done_meta <= done_i;
            done_s    <= done_meta;
        end
    end

    // State, counter and registered pin/flag outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            program_b_q <= 1'b1;
            init_b_q    <= 1'b1;
            gready_q    <= 1'b0;
            prog_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            program_b_q <= program_b_d;
            init_b_q    <= init_b_d;
            gready_q    <= gready_d;
            prog_err_q  <= prog_err_d;
        end
    end

    // Next-state logic; registered outputs change only on transitions, and
    // gready only ever moves while the bus is idle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        program_b_d = program_b_q;
        init_b_d    = init_b_q;
        gready_d    = gready_q;
        prog_err_d  = prog_err_q;
        cnt_inc     = cnt_q + 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (prog_req_i) begin
                    state_d = ST_REQ_WAIT;
                end else if (done_s) begin
                    state_d = ST_READY;
                    if (!bus_busy_i) gready_d = 1'b1;
                end else if (!bus_busy_i) begin
                    // Finishes a READY->IDLE drop that happened mid-transaction.
                    gready_d = 1'b0;
                end
            end

            ST_REQ_WAIT: begin
                if (!bus_busy_i) begin
                    state_d     = ST_PROG_LOW;
                    gready_d    = 1'b0;
                    program_b_d = 1'b0;
                    init_b_d    = 1'b1;
                    prog_err_d  = 1'b0;
                    cnt_d       = '0;
                end
            end

            ST_PROG_LOW: begin
                if (prog_req_i) begin
                    state_d     = ST_REQ_WAIT;
                    cnt_d       = '0;
                    program_b_d = 1'b1;
                    init_b_d    = 1'b1;
                end else if (cnt_q == PROG_LAST) begin
                    state_d  = ST_GAP;
                    init_b_d = 1'b0;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            ST_GAP: begin
                if (prog_req_i) begin
                    state_d     = ST_REQ_WAIT;
                    cnt_d       = '0;
                    program_b_d = 1'b1;
                    init_b_d    = 1'b1;
                end else if (cnt_q == GAP_LAST) begin
                    state_d     = ST_INIT_HOLD;
                    program_b_d = 1'b1;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            ST_INIT_HOLD: begin
                if (prog_req_i) begin
                    state_d     = ST_REQ_WAIT;
                    cnt_d       = '0;
                    program_b_d = 1'b1;
                    init_b_d    = 1'b1;
                end else if (cnt_q == INIT_LAST) begin
                    state_d  = ST_LOAD;
                    init_b_d = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            ST_LOAD: begin
                if (prog_req_i) begin
                    state_d     = ST_REQ_WAIT;
                    cnt_d       = '0;
                    program_b_d = 1'b1;
                    init_b_d    = 1'b1;
                end else if (done_s) begin
                    state_d = ST_READY;
                    if (!bus_busy_i) gready_d = 1'b1;
                end else if (cnt_inc == TIMEOUT_LAST) begin
                    // Transition on the edge the count would hit all-ones, so
                    // LOAD lasts exactly 2^TIMEOUT_BITS-1 cycles.
                    state_d    = ST_ERROR;
                    prog_err_d = 1'b1;
                    gready_d   = 1'b0;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            ST_READY: begin
                if (prog_req_i) begin
                    state_d = ST_REQ_WAIT;
                end else if (!done_s) begin
                    state_d = ST_IDLE;
                    if (!bus_busy_i) gready_d = 1'b0;
                end else if (!bus_busy_i) begin
                    gready_d = 1'b1;
                end
            end

            ST_ERROR: begin
                program_b_d = 1'b1;
                init_b_d    = 1'b1;
                gready_d    = 1'b0;
                prog_err_d  = 1'b1;
                if (prog_req_i) state_d = ST_REQ_WAIT;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign program_b_o = program_b_q;
    assign init_b_o    = init_b_q;
    assign gready_o    = gready_q;
    assign prog_err_o  = prog_err_q;
    assign state_o     = state_q;

endmodule

// File: rtl/glitc_prog_ctrl.sv
// Quad GLITC configuration sequencer: four independent channels sharing the
// GLITCBUS busy indication, with per-channel state packed onto state_debug_o.
module glitc_prog_ctrl
    import glitc_prog_pkg::*;
#(
    parameter int unsigned PROG_CYCLES  = 64,
    parameter int unsigned GAP_CYCLES   = 16,
    parameter int unsigned INIT_CYCLES  = 64,
    parameter int unsigned TIMEOUT_BITS = 24
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic [NUM_GLITC-1:0]           prog_req_i,
    input  logic                           bus_busy_i,
    input  logic [NUM_GLITC-1:0]           done_i,
    output logic [NUM_GLITC-1:0]           program_b_o,
    output logic [NUM_GLITC-1:0]           init_b_o,
    output logic [NUM_GLITC-1:0]           gready_o,
    output logic [NUM_GLITC-1:0]           prog_err_o,
    output logic [NUM_GLITC*STATE_W-1:0]   state_debug_o
);

    for (genvar g = 0; g < NUM_GLITC; g++) begin : g_ch
        glitc_prog_channel #(
            .PROG_CYCLES  (PROG_CYCLES),
            .GAP_CYCLES   (GAP_CYCLES),
            .INIT_CYCLES  (INIT_CYCLES),
            .TIMEOUT_BITS (TIMEOUT_BITS)
        ) u_ch (
            .clk_i       (clk_i),
            .rst_n_i     (rst_n_i),
            .prog_req_i  (prog_req_i[g]),
            .bus_busy_i  (bus_busy_i),
            .done_i      (done_i[g]),
            .program_b_o (program_b_o[g]),
            .init_b_o    (init_b_o[g]),
            .gready_o    (gready_o[g]),
            .prog_err_o  (prog_err_o[g]),
            .state_o     (state_debug_o[g*STATE_W +: STATE_W])
        );
    end

endmodule
